divisor_frecuencia_multi: RTL and testbench

- Multi-channel programmable clock-enable/waveform generator. Successor to the fixed single-channel toggle divider.
- Each channel produces a square wave with programmable period and high time, plus a one-cycle tick at each period start.
- Channels are configured at run time through a simple register write port.
- Sits between the system clock and slow consumers: display multiplexing, debouncers, blinkers.

---
 rtl/divisor_frecuencia_multi.sv | 116 +++++++++++
 tb/tb_divisor_frecuencia_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_frecuencia_multi.sv
// ============================================================================
// Module  : divisor_frecuencia_multi
// Brief   : Multi-channel programmable waveform / tick generator with
//           shadowed period and high-time registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_frecuencia_multi #(
    parameter int             NCH        = 4,
    parameter int             NBITS      = 20,
    parameter int             PERIOD_RST = 600002,
    parameter int             HIGH_RST   = 300001,
    parameter logic [NCH-1:0] EN_RST     = {NCH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             wr_en,
    input  logic [1:0]       wr_sel,
    input  logic [3:0]       wr_ch,
    input  logic [NBITS-1:0] wr_data,
    output logic [NCH-1:0]   salida,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy
);

    localparam logic [1:0]       c_SEL_PER  = 2'd0;
    localparam logic [1:0]       c_SEL_HIGH = 2'd1;
    localparam logic [1:0]       c_SEL_EN   = 2'd2;
    localparam logic [NBITS-1:0] c_P_RST    = NBITS'(PERIOD_RST);
    localparam logic [NBITS-1:0] c_H_RST    = NBITS'(HIGH_RST);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [NBITS-1:0] r_cnt_q, w_cnt_d;
        logic [NBITS-1:0] r_ps_q,  w_ps_d;
        logic [NBITS-1:0] r_pa_q,  w_pa_d;
        logic [NBITS-1:0] r_hs_q,  w_hs_d;
        logic [NBITS-1:0] r_ha_q,  w_ha_d;
        logic             r_en_q,  w_en_d;
        logic             r_busy_q, w_busy_d;
        logic             r_sal_q, w_sal_d;
        logic             r_tick_q, w_tick_d;
        logic             r_run_q;
        logic             w_hit, w_wr_p, w_wr_h, w_wr_e;
        logic             w_run, w_steady, w_wrap;

        // Channel indices >= NCH never match any generated channel
        assign w_hit    = wr_en & (wr_ch == 4'(gi));
        assign w_wr_p   = w_hit & (wr_sel == c_SEL_PER);
        assign w_wr_h   = w_hit & (wr_sel == c_SEL_HIGH);
        assign w_wr_e   = w_hit & (wr_sel == c_SEL_EN);

        assign w_run    = r_en_q & en[gi] & (r_pa_q >= NBITS'(2));
        assign w_steady = w_run & r_run_q;
        assign w_wrap   = w_steady & (r_cnt_q == (r_pa_q - NBITS'(1)));

        always_comb begin
            w_ps_d   = w_wr_p ? wr_data : r_ps_q;
            w_hs_d   = w_wr_h ? wr_data : r_hs_q;
            w_en_d   = w_wr_e ? wr_data[0] : r_en_q;
            w_pa_d   = r_pa_q;
            w_ha_d   = r_ha_q;
            w_busy_d = r_busy_q | w_wr_p | w_wr_h;
            w_cnt_d  = '0;
            if (!w_steady) begin
                // Idle or start edge: shadow flows straight to active
                w_pa_d   = r_ps_q;
                w_ha_d   = r_hs_q;
                w_busy_d = w_wr_p | w_wr_h;
            end else if (w_wrap) begin
                // Period boundary; a write landing here bypasses the shadow
                w_pa_d   = w_ps_d;
                w_ha_d   = w_hs_d;
                w_busy_d = 1'b0;
            end else begin
                w_cnt_d  = r_cnt_q + NBITS'(1);
            end
            w_tick_d = w_run & (w_cnt_d == '0);
            w_sal_d  = w_run & (w_cnt_d < w_ha_d);
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_cnt_q  <= '0;
                r_ps_q   <= c_P_RST;
                r_pa_q   <= c_P_RST;
                r_hs_q   <= c_H_RST;
                r_ha_q   <= c_H_RST;
                r_en_q   <= EN_RST[gi];
                r_busy_q <= 1'b0;
                r_sal_q  <= 1'b0;
                r_tick_q <= 1'b0;
                r_run_q  <= 1'b0;
            end else begin
                r_cnt_q  <= w_cnt_d;
                r_ps_q   <= w_ps_d;
                r_pa_q   <= w_pa_d;
                r_hs_q   <= w_hs_d;
                r_ha_q   <= w_ha_d;
                r_en_q   <= w_en_d;
                r_busy_q <= w_busy_d;
                r_sal_q  <= w_sal_d;
                r_tick_q <= w_tick_d;
                r_run_q  <= w_run;
            end
        end

        assign salida[gi] = r_sal_q;
        assign tick[gi]   = r_tick_q;
        assign busy[gi]   = r_busy_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_divisor_frecuencia_multi.sv
// ============================================================================
// Module  : tb_divisor_frecuencia_multi
// Brief   : Directed self-checking bench for divisor_frecuencia_multi.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divisor_frecuencia_multi;

    localparam int NCH   = 4;
    localparam int NBITS = 20;

    logic             clock   = 1'b0;
    logic             reset   = 1'b1;
    logic [NCH-1:0]   en      = '0;
    logic             wr_en   = 1'b0;
    logic [1:0]       wr_sel  = '0;
    logic [3:0]       wr_ch   = '0;
    logic [NBITS-1:0] wr_data = '0;
    logic [NCH-1:0]   salida, tick, busy;

    int n_vec = 0;
    int n_err = 0;

    divisor_frecuencia_multi #(
        .NCH        (NCH),
        .NBITS      (NBITS),
        .PERIOD_RST (12),
        .HIGH_RST   (5),
        .EN_RST     (4'hF)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .salida  (salida),
        .tick    (tick),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] ch, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_ch   = ch;
        wr_data = NBITS'(data);
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        // Reset state
        steps(2);
        chkv("rst_salida", salida, 4'b0000);
        chkv("rst_tick",   tick,   4'b0000);
        chkv("rst_busy",   busy,   4'b0000);
        reset = 1'b0;

        // ch0 P=4 H=2 while idle: busy pulses, then runs 1,1,0,0
        wr(2'd0, 4'd0, 4);
        chkv("idle_busy_p", busy, 4'b0001);
        wr(2'd1, 4'd0, 2);
        chkv("idle_busy_h", busy, 4'b0001);
        step();
        chkv("idle_busy_clr", busy, 4'b0000);
        en = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            step();
            chkb("p4_salida", salida[0], (k % 4) < 2);
            chkb("p4_tick",   tick[0],   (k % 4) == 0);
            chkv("p4_others", salida & 4'b1110, 4'b0000);
        end

        // ch0 P=10 H=5, then P=6 written at cnt=3
        en = 4'b0000;
        step();
        chkb("stop_salida", salida[0], 1'b0);
        wr(2'd0, 4'd0, 10);
        wr(2'd1, 4'd0, 5);
        step();
        en = 4'b0001;
        step();
        chkb("p10_start_tick", tick[0], 1'b1);
        steps(3);
        wr(2'd0, 4'd0, 6);
        chkb("p10_busy_set", busy[0],   1'b1);
        chkb("p10_sal_c4",   salida[0], 1'b1);
        steps(5);
        chkb("p10_busy_c9",  busy[0],   1'b1);
        chkb("p10_sal_c9",   salida[0], 1'b0);
        chkb("p10_tick_c9",  tick[0],   1'b0);
        step();
        chkb("p10_wrap_tick", tick[0],   1'b1);
        chkb("p10_wrap_busy", busy[0],   1'b0);
        chkb("p10_wrap_sal",  salida[0], 1'b1);
        steps(5);
        chkb("p6_tick_c5", tick[0],   1'b0);
        chkb("p6_sal_c5",  salida[0], 1'b0);
        step();
        chkb("p6_wrap_tick", tick[0], 1'b1);

        // ch2 P=5, P=8 written exactly on the wrap edge
        wr(2'd0, 4'd2, 5);
        step();
        en = 4'b0101;
        step();
        chkb("ch2_start_tick", tick[2], 1'b1);
        steps(4);
        chkb("ch2_c4_tick", tick[2], 1'b0);
        wr(2'd0, 4'd2, 8);
        chkb("ch2_byp_tick", tick[2], 1'b1);
        chkb("ch2_byp_busy", busy[2], 1'b0);
        for (int k = 1; k < 8; k++) begin
            step();
            chkb("ch2_p8_tick", tick[2], 1'b0);
            chkb("ch2_p8_busy", busy[2], 1'b0);
        end
        step();
        chkb("ch2_p8_wrap", tick[2], 1'b1);

        // ch3 boundaries: H=0, H=P=7, P=1
        wr(2'd0, 4'd3, 3);
        wr(2'd1, 4'd3, 0);
        step();
        en = 4'b1101;
        for (int k = 0; k < 6; k++) begin
            step();
            chkb("h0_salida", salida[3], 1'b0);
            chkb("h0_tick",   tick[3],   (k % 3) == 0);
        end
        en = 4'b0101;
        step();
        wr(2'd0, 4'd3, 7);
        wr(2'd1, 4'd3, 7);
        step();
        en = 4'b1101;
        for (int k = 0; k < 9; k++) begin
            step();
            chkb("heqp_salida", salida[3], 1'b1);
            chkb("heqp_tick",   tick[3],   (k % 7) == 0);
        end
        en = 4'b0101;
        step();
        wr(2'd0, 4'd3, 1);
        step();
        en = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            step();
            chkb("p1_salida", salida[3], 1'b0);
            chkb("p1_tick",   tick[3],   1'b0);
        end

        // ch1 run enable dropped at cnt=3 and re-raised
        wr(2'd0, 4'd1, 10);
        wr(2'd1, 4'd1, 4);
        step();
        en = 4'b0111;
        step();
        chkb("en1_start_tick", tick[1], 1'b1);
        steps(3);
        chkb("en1_c3_sal", salida[1], 1'b1);
        en = 4'b0101;
        step();
        chkb("en1_off_sal",  salida[1], 1'b0);
        chkb("en1_off_tick", tick[1],   1'b0);
        steps(4);
        chkb("en1_off4_sal",  salida[1], 1'b0);
        chkb("en1_off4_tick", tick[1],   1'b0);
        en = 4'b0111;
        step();
        chkb("en1_re_tick", tick[1],   1'b1);
        chkb("en1_re_sal",  salida[1], 1'b1);
        steps(4);
        chkb("en1_re_c4_sal", salida[1], 1'b0);

        // Pending shadow write, then reset at cnt=7 with a ch9 write
        wr(2'd1, 4'd1, 2);
        chkb("pend_busy", busy[1], 1'b1);
        steps(2);
        chkb("pend_busy_c7", busy[1], 1'b1);
        reset = 1'b1;
        en    = 4'b0000;
        wr(2'd0, 4'd9, 3);
        chkv("rst2_salida", salida, 4'b0000);
        chkv("rst2_tick",   tick,   4'b0000);
        chkv("rst2_busy",   busy,   4'b0000);
        reset = 1'b0;

        // All channels restart from reset period 12 / high 5
        en = 4'b1111;
        wr(2'd0, 4'd9, 3);
        chkv("post_tick", tick,   4'b1111);
        chkv("post_sal",  salida, 4'b1111);
        chkv("ch9_busy",  busy,   4'b0000);
        steps(4);
        chkv("post_sal_c4", salida, 4'b1111);
        step();
        chkv("post_sal_c5", salida, 4'b0000);
        steps(6);
        chkv("post_tick_c11", tick, 4'b0000);
        step();
        chkv("post_wrap_tick", tick,   4'b1111);
        chkv("post_wrap_sal",  salida, 4'b1111);

        // Enable-register write takes effect one edge later
        wr(2'd2, 4'd2, 0);
        chkb("ebit_still_on", salida[2], 1'b1);
        step();
        chkb("ebit_off_sal", salida[2], 1'b0);
        chkb("ebit_ch0_on",  salida[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
